// File: rtl/la_pkg.sv
// Shared constants and state encoding for the logic-analyser capture path.
package la_pkg;

  localparam int unsigned ENTRIES = 384;
  localparam int unsigned LOG2    = 9;
  localparam int unsigned DecW    = 15;

  typedef enum logic [1:0] {
    StIdle,
    StCapt,
    StPost,
    StDone
  } cap_state_e;

endpackage

// File: rtl/dec_strobe.sv
// Sample-rate decimator: emits one strobe per 2**decimator accepted samples.
module dec_strobe
  import la_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       wrt_smpl,
  input  logic [3:0] decimator,
  output logic       smpl_stb
);

  logic [DecW-1:0] dec_cnt_q, dec_cnt_d;
  logic [DecW-1:0] dec_max;

  always_comb begin
    dec_max   = DecW'((16'd1 << decimator) - 16'd1);
    smpl_stb  = wrt_smpl && (dec_cnt_q == dec_max);
    dec_cnt_d = dec_cnt_q;
    if (clr || smpl_stb) begin
      dec_cnt_d = '0;
    end else if (wrt_smpl) begin
      dec_cnt_d = dec_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt_q <= '0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: circular pre-trigger history, post-trigger fill, done handshake.
module capture_ctrl #(
  parameter int unsigned ENTRIES = 384,
  parameter int unsigned LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture_en,
  input  logic            capture_done,
  input  logic [3:0]      decimator,
  input  logic [LOG2-1:0] trig_pos,
  input  logic            wrt_smpl,
  input  logic            triggered,
  output logic            we,
  output logic [LOG2-1:0] waddr,
  output logic            armed,
  output logic            set_capture_done,
  output logic [LOG2-1:0] ram_addr
);
  import la_pkg::*;

  localparam logic [LOG2-1:0] LastAddr = LOG2'(ENTRIES - 1);
  localparam logic [LOG2:0]   EntriesW = (LOG2 + 1)'(ENTRIES);

  cap_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [LOG2-1:0] waddr_q, waddr_d;
  logic [LOG2:0]   smpl_cnt_q, smpl_cnt_d;
  logic [LOG2-1:0] trig_cnt_q, trig_cnt_d;
  logic [LOG2-1:0] ram_addr_q, ram_addr_d;
  logic            done_pulse_q, done_pulse_d;

  logic            running;
  logic            dec_clr;
  logic            dec_wrt;
  logic            smpl_stb;
  logic [LOG2-1:0] trig_pos_eff;
  logic [LOG2-1:0] waddr_inc;
  logic            armed_c;

  assign running = (state_q == StCapt) || (state_q == StPost);
  assign dec_clr = (state_q == StIdle);
  assign dec_wrt = wrt_smpl && running && capture_en;

  dec_strobe u_dec_strobe (
    .clk       (clk),
    .rst       (rst),
    .clr       (dec_clr),
    .wrt_smpl  (dec_wrt),
    .decimator (decimator),
    .smpl_stb  (smpl_stb)
  );

  always_comb begin
    trig_pos_eff = (trig_pos > LastAddr) ? LastAddr : trig_pos;
    waddr_inc    = (waddr_q == LastAddr) ? '0 : waddr_q + 1'b1;
    armed_c      = (state_q == StCapt) &&
                   ((smpl_cnt_q + {1'b0, trig_pos_eff}) >= EntriesW);
  end

  always_comb begin
    state_d      = state_q;
    we_d         = 1'b0;
    smpl_cnt_d   = smpl_cnt_q;
    trig_cnt_d   = trig_cnt_q;
    ram_addr_d   = ram_addr_q;
    done_pulse_d = 1'b0;
    // Address advances once the registered write has been presented.
    waddr_d      = we_q ? waddr_inc : waddr_q;

    unique case (state_q)
      StIdle: begin
        if (capture_en && !capture_done) begin
          state_d    = StCapt;
          smpl_cnt_d = '0;
          trig_cnt_d = '0;
        end
      end
      StCapt: begin
        if (!capture_en) begin
          state_d = StIdle;
        end else begin
          if (smpl_stb) begin
            we_d = 1'b1;
            if (smpl_cnt_q != EntriesW) begin
              smpl_cnt_d = smpl_cnt_q + 1'b1;
            end
          end
          // A sample accepted alongside the trigger is still pre-trigger history;
          // with no post window it must finish writing before DONE.
          if (triggered && armed_c) begin
            state_d = ((trig_pos_eff == '0) && !smpl_stb) ? StDone : StPost;
          end
        end
      end
      StPost: begin
        if (!capture_en) begin
          state_d = StIdle;
        end else if (trig_cnt_q == trig_pos_eff) begin
          state_d = StDone;
        end else if (smpl_stb) begin
          we_d       = 1'b1;
          trig_cnt_d = trig_cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (!capture_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_d == StDone) && (state_q != StDone)) begin
      done_pulse_d = 1'b1;
      ram_addr_d   = waddr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      smpl_cnt_q   <= '0;
      trig_cnt_q   <= '0;
      ram_addr_q   <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      smpl_cnt_q   <= smpl_cnt_d;
      trig_cnt_q   <= trig_cnt_d;
      ram_addr_q   <= ram_addr_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign we               = we_q;
  assign waddr            = waddr_q;
  assign armed            = armed_c;
  assign set_capture_done = done_pulse_q;
  assign ram_addr         = ram_addr_q;

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameters: ENTRIES, default 384, RAMqueue depth; LOG2, default 9, address width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 capture_en  input  1  run enable from cmd_cfg TrigCfg[4].
REQ-005 capture_done  input  1  done flag from cmd_cfg TrigCfg[5].
REQ-006 decimator  input  4  sample rate divider exponent from cmd_cfg.
REQ-007 trig_pos  input  LOG2  post-trigger sample count, {trig_posH,trig_posL} from cmd_cfg.
REQ-008 wrt_smpl  input  1  one-cycle strobe per new channel sample.
REQ-009 triggered  input  1  trigger-logic event, level or pulse.
REQ-010 we  output  1  RAMqueue write enable, shared by all five channel RAMs.
REQ-011 waddr  output  LOG2  RAMqueue write address.
REQ-012 armed  output  1  pre-trigger history sufficient; trigger logic qualifies on it.
REQ-013 set_capture_done  output  1  one-cycle pulse to cmd_cfg.
REQ-014 ram_addr  output  LOG2  oldest-sample address, to cmd_cfg dump start.

Function
REQ-015 States: IDLE, CAPT (pre-trigger), POST (post-trigger), DONE.
REQ-016 IDLE->CAPT when capture_en=1 and capture_done=0; on entry clear smpl_cnt, trig_cnt, dec_cnt; waddr retained.
REQ-017 Decimation: in CAPT/POST each wrt_smpl increments dec_cnt (15 bits); qualifying sample when dec_cnt==(1<<decimator)-1, dec_cnt then clears; decimator=0 qualifies every wrt_smpl.
REQ-018 Qualifying sample registers we=1 for exactly one cycle, the cycle after wrt_smpl, with waddr holding the write address during that cycle.
REQ-019 waddr increments after each write; ENTRIES-1 wraps to 0 (no power-of-2 assumption).
REQ-020 smpl_cnt counts CAPT writes, saturates at ENTRIES.
REQ-021 Effective trig_pos clamped to ENTRIES-1 when input exceeds it.
REQ-022 armed=1 when smpl_cnt + trig_pos >= ENTRIES (LOG2+1-bit compare), in CAPT only; 0 elsewhere.
REQ-023 CAPT->POST when triggered=1 and armed=1; triggered while unarmed ignored.
REQ-024 POST: each write increments trig_cnt; write making trig_cnt==trig_pos -> DONE next cycle.
REQ-025 trig_pos=0: trigger goes CAPT->DONE directly, no post-trigger write.
REQ-026 Entering DONE: set_capture_done=1 one cycle; ram_addr<=waddr (next address = oldest sample); we=0 in DONE.
REQ-027 DONE->IDLE when capture_done=0 (host cleared).
REQ-028 capture_en=0 in CAPT/POST -> IDLE next cycle, pending write suppressed, no set_capture_done, ram_addr unchanged.
REQ-029 wrt_smpl and triggered same cycle: sample counts toward CAPT (armed evaluated on pre-update smpl_cnt).

Reset
REQ-030 rst=1: state IDLE; we=0, waddr=0, armed=0, set_capture_done=0, ram_addr=0; all counters 0.
REQ-031 rst mid-capture aborts immediately; no set_capture_done pulse.

Structure
REQ-032 ENTRIES, LOG2 and the state enum live in shared package la_pkg.
REQ-033 Decimation counter is sub-module dec_strobe (clk, rst, clr, wrt_smpl, decimator -> smpl_stb).

Verification
REQ-034 decimator=0, trig_pos=100, wrt_smpl every cycle, trigger at armed rise -> armed after 284 writes, 100 post writes, set_capture_done once, ram_addr=waddr at done.
REQ-035 decimator=3, wrt_smpl continuous -> we every 8th wrt_smpl; waddr 383 wraps to 0.
REQ-036 trig_pos=0, trigger when armed -> DONE with no post write; trig_pos=500 -> behaves as 383.
REQ-037 triggered held high from start -> ignored until armed, then POST; capture_en dropped in POST -> IDLE, no done pulse.
REQ-038 DONE with capture_done=1 held -> stays DONE, we=0; clear capture_done -> IDLE; re-enable restarts capture.
REQ-039 rst asserted mid-POST -> next cycle all outputs at reset values.
